shift_add_multiplier: RTL

Sequential unsigned shift-and-add multiplier that drives the 12-bit ripple `Adder` datapath stage. It takes two W-bit operands on a start pulse, feeds partial products to the external adder once per cycle, and captures the adder sum back into its accumulator. After W add cycles it presents a 2W-bit product with a one-cycle done pulse. It sits directly upstream and downstream of the `Adder` instance: it sources A/B/Cin and consumes S.

---
 rtl/shift_add_multiplier.sv | 114 +++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier that drives an external
// combinational ripple adder. One partial product is added per cycle:
// W add cycles, then a one-cycle DONE with the product presented.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for Start; adder operands forced to zero
// CALC   | one partial-product add per cycle, W cycles in total
// DONE   | Product valid, Done high for exactly one cycle
module shift_add_multiplier #(
    parameter int W = 6,
    parameter int N = 2 * W
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [W-1:0] Mcand,
    input  logic [W-1:0] Mplier,
    output logic [N-1:0] AddA,
    output logic [N-1:0] AddB,
    output logic         AddCin,
    input  logic [N-1:0] AddS,
    output logic [N-1:0] Product,
    output logic         Busy,
    output logic         Done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [N-1:0]  acc;
    logic [N-1:0]  mc_reg;
    logic [W-1:0]  mp_reg;
    logic [CW-1:0] cnt;
    logic [N-1:0]  product_q;
    logic          busy_q;
    logic          done_q;

    // Next-state decision; CALC exits after the W-th add.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start) state_nxt = S_CALC;
            S_CALC:  if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Adder operands: accumulator plus multiplicand gated by the current multiplier LSB.
    always_comb begin
        AddA = '0;
        AddB = '0;
        if (state == S_CALC) begin
            AddA = acc;
            AddB = mp_reg[0] ? mc_reg : '0;
        end
    end

    assign AddCin  = 1'b0;
    assign Product = product_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

    // State register plus registered Busy/Done flags so the outputs never glitch.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == S_CALC);
            done_q <= (state_nxt == S_DONE);
        end
    end

    // Datapath: operand capture on accept, one shift/add step per CALC cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc    <= '0;
            mc_reg <= '0;
            mp_reg <= '0;
            cnt    <= '0;
        end else if (state == S_IDLE && Start) begin
            acc    <= '0;
            mc_reg <= {{(N - W){1'b0}}, Mcand};
            mp_reg <= Mplier;
            cnt    <= '0;
        end else if (state == S_CALC) begin
            acc    <= AddS;
            mc_reg <= mc_reg << 1;
            mp_reg <= mp_reg >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // Product is captured from the final sum on entry to DONE, so it is
    // already valid while Done is high and is held until the next result.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            product_q <= '0;
        end else if (state == S_CALC && cnt == CNT_LAST) begin
            product_q <= AddS;
        end
    end

endmodule
